bcd_seg_display: RTL and testbench
==================================

# bcd_seg_display

Parametrised binary-to-decimal seven-segment display driver for the battle board. It converts a WIDTH-bit unsigned value (HP, damage, accuracy, score) into DIGITS decimal digits with an iterative shift-add-3 (double-dabble) engine and holds the result on active-low segment outputs. It supports leading-zero blanking, an overflow indication and a blink mode. It replaces the fixed 4-bit, two-digit decoders on HEX pairs where values exceed 15 or need more digits.

## Interface
- WIDTH, 8: binary input width; legal range 4..20.
- DIGITS, 3: number of displayed decimal digits; legal range 1..6.
- BLINK_DIV, 25_000_000: clk cycles per blink half-period; ≥1.
- clk  in  1  system clock (CLOCK_50 at top level).
- rst  in  1  reset; asynchronous, active-high.
- load  in  1  request conversion of value; sampled on rising clk.
- value  in  WIDTH  unsigned binary to display.
- blank_lz  in  1  1 = blank leading zero digits.
- blink_en  in  1  1 = display flashes at BLINK_DIV rate.
- busy  out  1  conversion in progress (SHIFT or DONE state).
- done  out  1  one-cycle pulse; display registers just updated.
- overflow  out  1  displayed value exceeds 10^DIGITS-1.
- seg  out  7*DIGITS  active-low segments; seg[7i+6:7i] is digit i (digit 0 = ones); bit order g..a, "0" = 7'b1000000.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if load or pending set → capture value (from pending slot if set, else from value), clear pending, flag ovf_next = (captured > 10^DIGITS-1), clear BCD accumulator, count = WIDTH, → SHIFT.
- SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, bin} left by 1. Decrement count; at count 1 → DONE.
- DONE: copy low DIGITS nibbles to display registers, overflow ← ovf_next, → IDLE; done pulses in the following cycle.
- Internal BCD width: 4*max(DIGITS, ceil(WIDTH/3)) bits, so no intermediate truncation.
- Pending slot, one deep: load while busy stores value; later loads overwrite it (latest wins). It is consumed at the next IDLE cycle.
- Output mapping (combinational from registers):
  - overflow=1 → every digit shows dash 7'b0111111.
  - Otherwise, with blank_lz=1, digits above the most significant nonzero show 7'b1111111; digit 0 is never blanked.
  - blink_en=1 and blink phase=1 → all digits 7'b1111111, overriding the above.
- Blink counter: free-running. Phase toggles every BLINK_DIV cycles regardless of blink_en.

## Timing
- Load sampled at edge E0 in IDLE → busy high from E0 until E(WIDTH+1).
- Display registers and overflow update at E(WIDTH+1). done is high for exactly the cycle after E(WIDTH+1), and seg shows the new value in that same cycle.
- Conversion latency is WIDTH+1 cycles. With pending set, the next conversion starts one IDLE cycle later, giving a WIDTH+2 cycle period.
- Load at E(WIDTH+1) (state DONE) goes to pending, not lost.
- Reset values: state IDLE, busy 0, done 0, overflow 0, pending clear, display digits 0, blink phase 0, blink counter 0. seg after reset shows "0" on digit 0; upper digits show "0", or blank if blank_lz=1.
- Reset mid-conversion: aborts immediately, discards pending and partial result, returns to reset values.
- blank_lz and blink_en changes take effect combinationally; they never restart a conversion.

## Structure
- Shared package bcd_seg_pkg holds:
  - SEG_DIGIT[0:9], the active-low patterns.
  - SEG_DASH = 7'b0111111.
  - SEG_OFF = 7'b1111111.
  - State enum typedef {IDLE, SHIFT, DONE}.
  - Function pow10(n) for the overflow threshold.
- One sub-module: bcd_to_seg7, which maps a 4-bit BCD nibble to 7 segments. Non-decimal input gives SEG_DASH. It is instantiated DIGITS times via generate.

## Test plan
- WIDTH=8, DIGITS=3, blank_lz=0, load value=255 → busy for 9 cycles; done pulse in cycle 10; seg = "2","5","5"; overflow 0.
- Same instance with blank_lz=1: load 7 → digits 2,1 = SEG_OFF, digit 0 = "7". Load 0 → only digit 0 lit, showing "0".
- DIGITS=2 instance, load 100 → all digits SEG_DASH, overflow 1. Then load 99 → "99", overflow 0.
- Load 37, then load 42 and 13 while busy → 37 displayed first; 13 displayed one conversion later; 42 never displayed; exactly two done pulses.
- BLINK_DIV=4, blink_en=1, value 5 shown → seg alternates "5" and all-off every 4 cycles. blink_en=0 → steady "5".
- Load 200, assert rst at SHIFT cycle 4 → busy 0 and seg "0" immediately; no done pulse; the next load 9 converts normally.

Source files
------------

// File: rtl/bcd_seg_pkg.sv
// Shared definitions for the seven-segment BCD display driver.
// Holds the active-low segment patterns (bit order g..a), the converter
// state encoding and a power-of-ten helper used for the overflow threshold.
package bcd_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_seg_display_bcd_to_seg7.sv
// Maps one BCD nibble to an active-low seven-segment pattern.
// Ports:
//   bcd_i  4-bit BCD digit
//   seg_o  segments g..a, active low; non-decimal codes show a dash
module bcd_to_seg7
    import bcd_seg_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (bcd_i <= 4'd9) begin
            seg_o = SEG_DIGIT[bcd_i];
        end
    end

endmodule

// File: rtl/bcd_seg_display.sv
// Binary-to-decimal seven-segment driver using an iterative double-dabble
// engine (one shift per clock). Result is held in display registers and
// mapped to active-low segments with leading-zero blanking, overflow dashes
// and a free-running blink.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load, value    conversion request and WIDTH-bit unsigned operand
//   blank_lz       blank leading zero digits (digit 0 always lit)
//   blink_en       blank the whole display during blink phase 1
//   busy           conversion in progress (SHIFT or DONE)
//   done           one-cycle pulse after the display registers update
//   overflow       displayed value does not fit in DIGITS digits
//   seg            7 bits per digit, digit 0 in seg[6:0]
//   dbg_state      current converter state
// Handshake: load is a single-cycle request sampled on every rising edge;
// a load seen while busy is parked in a one-deep slot (latest wins) and is
// converted right after the current conversion finishes.
module bcd_seg_display
    import bcd_seg_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIGITS    = 3,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH-1:0]      value,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   seg,
    output logic [1:0]            dbg_state
);

    // Enough BCD digits for the full input range so nothing is truncated
    // during conversion; only the low DIGITS nibbles are displayed.
    localparam int IDIG = (DIGITS > (WIDTH + 2) / 3) ? DIGITS : (WIDTH + 2) / 3;
    localparam int BW   = 4 * IDIG;
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int BDW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned MAXV = pow10(DIGITS) - 1;

    state_t              state_q, state_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [WIDTH-1:0]    bin_q, bin_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [WIDTH-1:0]    pend_val_q, pend_val_d;
    logic                ovf_next_q, ovf_next_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic [BDW-1:0]      blink_cnt_q;
    logic                blink_ph_q;

    logic [BW-1:0]       adj;
    logic [WIDTH-1:0]    cap;

    always_comb begin
        state_d    = state_q;
        bcd_d      = bcd_q;
        bin_d      = bin_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        ovf_next_d = ovf_next_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        // Add-3 correction on every nibble that would exceed 9 after doubling.
        adj = bcd_q;
        for (int i = 0; i < IDIG; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        cap = pend_q ? pend_val_q : value;

        if (load && (state_q != IDLE)) begin
            pend_d     = 1'b1;
            pend_val_d = value;
        end

        case (state_q)
            IDLE: begin
                if (load || pend_q) begin
                    bin_d      = cap;
                    bcd_d      = '0;
                    ovf_next_d = (32'(cap) > MAXV);
                    cnt_d      = CNTW'(WIDTH);
                    state_d    = SHIFT;
                    // A fresh load arriving while the parked value is
                    // consumed takes the slot instead of being dropped.
                    pend_d     = pend_q && load;
                    if (pend_q && load) begin
                        pend_val_d = value;
                    end
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_d  = bcd_q[4*DIGITS-1:0];
                ovf_d   = ovf_next_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bcd_q      <= '0;
            bin_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            ovf_next_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            bin_q      <= bin_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            ovf_next_q <= ovf_next_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    // Blink phase runs continuously so enabling blink never resyncs it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
        end else if (blink_cnt_q == BDW'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= ~blink_ph_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BDW'(1);
        end
    end

    logic [6:0]        raw [DIGITS];
    logic [DIGITS-1:0] lz;
    logic              zero_above;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_to_seg7 u_seg (
            .bcd_i (disp_q[4*g +: 4]),
            .seg_o (raw[g])
        );
    end

    // lz[i] marks digit i as a leading zero: it and every digit above are 0.
    always_comb begin
        lz         = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (disp_q[4*i +: 4] == 4'd0);
            lz[i]      = zero_above;
        end
    end

    always_comb begin
        seg = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (blink_en && blink_ph_q) begin
                seg[7*i +: 7] = SEG_OFF;
            end else if (ovf_q) begin
                seg[7*i +: 7] = SEG_DASH;
            end else if (blank_lz && lz[i]) begin
                seg[7*i +: 7] = SEG_OFF;
            end else begin
                seg[7*i +: 7] = raw[i];
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Bench for bcd_seg_display: a WIDTH=8/DIGITS=3/BLINK_DIV=4 instance (A)
// and a WIDTH=8/DIGITS=2 instance (B). Expected segment images come from a
// decimal reference model computed with division and modulo.
module tb_bcd_seg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        load_a = 1'b0, blank_a = 1'b0, blink_a = 1'b0;
    logic [7:0]  value_a = '0;
    logic        busy_a, done_a, ovf_a;
    logic [20:0] seg_a;
    logic [1:0]  st_a;

    logic        load_b = 1'b0, blank_b = 1'b0, blink_b = 1'b0;
    logic [7:0]  value_b = '0;
    logic        busy_b, done_b, ovf_b;
    logic [13:0] seg_b;
    logic [1:0]  st_b;

    int          tests = 0;
    int          fails = 0;
    int unsigned edge_n;
    logic [7:0]  exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bcd_seg_display #(.WIDTH(8), .DIGITS(3), .BLINK_DIV(4)) u_a (
        .clk(clk), .rst(rst), .load(load_a), .value(value_a),
        .blank_lz(blank_a), .blink_en(blink_a), .busy(busy_a),
        .done(done_a), .overflow(ovf_a), .seg(seg_a), .dbg_state(st_a)
    );

    bcd_seg_display #(.WIDTH(8), .DIGITS(2), .BLINK_DIV(3)) u_b (
        .clk(clk), .rst(rst), .load(load_b), .value(value_b),
        .blank_lz(blank_b), .blink_en(blink_b), .busy(busy_b),
        .done(done_b), .overflow(ovf_b), .seg(seg_b), .dbg_state(st_b)
    );

    // ---------------- reference model ----------------
    function automatic logic [41:0] exp_seg(input int unsigned v, input int nd,
                                            input bit blank, input bit off);
        logic [6:0] tab [10];
        logic [41:0] r;
        int unsigned p, pmax, d;
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        r = '1;
        pmax = 1;
        for (int i = 0; i < nd; i++) pmax = pmax * 10;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            if (off) begin
                r[7*i +: 7] = 7'h7F;
            end else if (v >= pmax) begin
                r[7*i +: 7] = 7'h3F;
            end else begin
                d = (v / p) % 10;
                if (blank && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
                else                         r[7*i +: 7] = tab[d];
            end
            p = p * 10;
        end
        return r;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Full conversion on A with cycle-exact busy/done timing checks.
    task automatic conv_a(input logic [7:0] v);
        logic [41:0] e;
        logic [7:0]  x;
        exp_q.push_back(v);
        @(negedge clk);
        value_a = v;
        load_a  = 1'b1;
        @(negedge clk);
        load_a  = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) @(negedge clk);
            check("a_busy", 64'(busy_a), 64'd1);
            check("a_nodone", 64'(done_a), 64'd0);
        end
        @(negedge clk);
        x = exp_q.pop_front();
        e = exp_seg(x, 3, blank_a, 1'b0);
        check("a_done", 64'(done_a), 64'd1);
        check("a_idle", 64'(busy_a), 64'd0);
        check("a_seg", 64'(seg_a), 64'(e[20:0]));
        check("a_ovf", 64'(ovf_a), 64'd0);
        @(negedge clk);
        check("a_done_pulse", 64'(done_a), 64'd0);
    endtask

    // Conversion on B with a bounded wait for done.
    task automatic conv_b(input logic [7:0] v);
        logic [41:0] e;
        logic [7:0]  x;
        int          n;
        exp_q.push_back(v);
        @(negedge clk);
        value_b = v;
        load_b  = 1'b1;
        @(negedge clk);
        load_b  = 1'b0;
        n = 1;
        while (!done_b && n < 20) begin
            @(negedge clk);
            n++;
        end
        x = exp_q.pop_front();
        e = exp_seg(x, 2, blank_b, 1'b0);
        check("b_latency", 64'(n), 64'd10);
        check("b_seg", 64'(seg_b), 64'(e[13:0]));
        check("b_ovf", 64'(ovf_b), 64'(x > 8'd99));
    endtask

    // ---------------- directed sequence ----------------
    logic [41:0] e;
    logic [7:0]  x;
    int          dones, first_n, second_n;

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_state", 64'(st_a), 64'd0);
        e = exp_seg(0, 3, 1'b0, 1'b0);
        check("rst_seg", 64'(seg_a), 64'(e[20:0]));
        blank_a = 1'b1;
        #1;
        e = exp_seg(0, 3, 1'b1, 1'b0);
        check("rst_seg_blank", 64'(seg_a), 64'(e[20:0]));
        blank_a = 1'b0;
        rst = 1'b0;

        // Main function and leading-zero blanking.
        conv_a(8'd255);
        blank_a = 1'b1;
        conv_a(8'd7);
        conv_a(8'd0);
        blank_a = 1'b0;
        #1;
        e = exp_seg(0, 3, 1'b0, 1'b0);
        check("blank_release", 64'(seg_a), 64'(e[20:0]));

        // Overflow on the two-digit instance.
        conv_b(8'd100);
        conv_b(8'd99);
        conv_b(8'd255);
        blank_b = 1'b1;
        conv_b(8'd5);

        // Pending slot: 42 overwritten by 13 (13 issued during DONE).
        exp_q.push_back(8'd37);
        exp_q.push_back(8'd13);
        dones = 0; first_n = 0; second_n = 0;
        @(negedge clk);
        value_a = 8'd37;
        load_a  = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_a) begin
                dones++;
                if (dones == 1) first_n = n;
                if (dones == 2) second_n = n;
                if (exp_q.size() > 0) begin
                    x = exp_q.pop_front();
                    e = exp_seg(x, 3, 1'b0, 1'b0);
                    check("pend_seg", 64'(seg_a), 64'(e[20:0]));
                end else begin
                    check("pend_extra_done", 64'(dones), 64'd2);
                end
            end
            load_a = 1'b0;
            if (n == 3) begin value_a = 8'd42; load_a = 1'b1; end
            if (n == 9) begin value_a = 8'd13; load_a = 1'b1; end
        end
        check("pend_dones", 64'(dones), 64'd2);
        check("pend_first", 64'(first_n), 64'd10);
        check("pend_second", 64'(second_n), 64'd20);

        // Reset in the middle of a conversion.
        @(negedge clk);
        value_a = 8'd200;
        load_a  = 1'b1;
        @(negedge clk);
        load_a  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 64'(busy_a), 64'd0);
        e = exp_seg(0, 3, 1'b0, 1'b0);
        check("mid_rst_seg", 64'(seg_a), 64'(e[20:0]));
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done_a) dones++;
        end
        check("mid_rst_nodone", 64'(dones), 64'd0);
        conv_a(8'd9);

        // Blink with phase derived from edges since reset.
        conv_a(8'd5);
        blink_a = 1'b1;
        for (int n = 0; n < 16; n++) begin
            #1;
            e = exp_seg(5, 3, 1'b0, ((edge_n / 4) % 2) == 1);
            check("blink_on", 64'(seg_a), 64'(e[20:0]));
            @(negedge clk);
        end
        blink_a = 1'b0;
        for (int n = 0; n < 6; n++) begin
            #1;
            e = exp_seg(5, 3, 1'b0, 1'b0);
            check("blink_off", 64'(seg_a), 64'(e[20:0]));
            @(negedge clk);
        end

        // Randomized conversions on both instances.
        for (int n = 0; n < 12; n++) begin
            blank_a = 1'($urandom_range(0, 1));
            conv_a(8'($urandom_range(0, 255)));
        end
        for (int n = 0; n < 12; n++) begin
            blank_b = 1'($urandom_range(0, 1));
            conv_b(8'($urandom_range(0, 255)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
